// File: rtl/gap_seqdet_pkg.sv
// Shared types and constants for the gap sequence detector.
package gap_seqdet_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEEN1 = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic MODE_OVL  = 1'b0;
    localparam logic MODE_NOVL = 1'b1;

    localparam int unsigned MATCH_CNT_W = 8;

endpackage

// File: rtl/gap_sequence_detector_zero_run_counter.sv
// Zero-run counter z and latched gap register gq for the gap sequence detector.
module zero_run_counter #(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          inc,
    input  logic [CW-1:0] gap_in,
    output logic          at_gap
);

    logic [CW-1:0] z_q, z_d;
    logic [CW-1:0] gq_q, gq_d;

    always_comb begin
        z_d  = z_q;
        gq_d = gq_q;
        if (load) begin
            z_d  = CW'(1);
            gq_d = gap_in;
        end else if (inc) begin
            z_d = z_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q  <= '0;
            gq_q <= '0;
        end else begin
            z_q  <= z_d;
            gq_q <= gq_d;
        end
    end

    assign at_gap = (z_q == gq_q);

endmodule

// File: rtl/gap_sequence_detector.sv
// Detects 1, exactly gap zeros, 1 on a synchronized serial input.
// Optional saturating match counter enabled by GAP_SEQDET_MATCH_CNT_EN.
module gap_sequence_detector
    import gap_seqdet_pkg::*;
#(
    parameter int unsigned CW          = 3,
    parameter int unsigned SYNC_STAGES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          J,
    input  logic [CW-1:0] gap,
    input  logic          mode,
    output logic          Y,
    output logic          busy
`ifdef GAP_SEQDET_MATCH_CNT_EN
    ,
    output logic [MATCH_CNT_W-1:0] match_cnt
`endif
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   js;

    state_e state_q, state_d;
    logic   mode_q, mode_d;
    logic   load, inc, at_gap;

    always_comb begin
        sync_d[0] = J;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign js = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= S_IDLE;
            mode_q  <= MODE_OVL;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    // Mode is latched with gq so a mid-frame change only affects the next frame.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        load    = 1'b0;
        inc     = 1'b0;
        if (en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (js) state_d = S_SEEN1;
                end
                S_SEEN1: begin
                    if (js) begin
                        state_d = S_SEEN1;
                    end else if (gap != '0) begin
                        state_d = S_COUNT;
                        load    = 1'b1;
                        mode_d  = mode;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_COUNT: begin
                    if (js) begin
                        state_d = at_gap ? S_DONE : S_SEEN1;
                    end else if (at_gap) begin
                        state_d = S_IDLE;
                    end else begin
                        inc = 1'b1;
                    end
                end
                S_DONE: begin
                    if (js) begin
                        state_d = S_SEEN1;
                    end else if (mode_q == MODE_NOVL || gap == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_COUNT;
                        load    = 1'b1;
                        mode_d  = mode;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        Y    = (state_q == S_DONE);
        busy = (state_q == S_COUNT);
    end

    zero_run_counter #(
        .CW(CW)
    ) u_zero_run_counter (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .inc    (inc),
        .gap_in (gap),
        .at_gap (at_gap)
    );

`ifdef GAP_SEQDET_MATCH_CNT_EN
    logic [MATCH_CNT_W-1:0] match_cnt_q, match_cnt_d;

    always_comb begin
        match_cnt_d = match_cnt_q;
        if (state_d == S_DONE && state_q != S_DONE && match_cnt_q != '1) begin
            match_cnt_d = match_cnt_q + MATCH_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt_q <= '0;
        end else begin
            match_cnt_q <= match_cnt_d;
        end
    end

    assign match_cnt = match_cnt_q;
`endif

endmodule

// File: tb/tb_gap_sequence_detector.sv
// Self-checking bench for gap_sequence_detector (CW=3, SYNC_STAGES=1).
module tb_gap_sequence_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       J = 1'b0;
    logic [2:0] gap = '0;
    logic       mode = 1'b0;
    logic       Y, busy;
`ifdef GAP_SEQDET_MATCH_CNT_EN
    logic [7:0] match_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic y;
        logic busy;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        string      name;
        logic [2:0] gap;
        logic       mode;
        int         len;
        logic [15:0] j;
        logic [15:0] y;
        logic [15:0] b;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    gap_sequence_detector #(
        .CW          (3),
        .SYNC_STAGES (1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .J    (J),
        .gap  (gap),
        .mode (mode),
        .Y    (Y),
        .busy (busy)
`ifdef GAP_SEQDET_MATCH_CNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Drive one sample, queue its expected outputs, compare after the edge.
    task automatic step(input string name, input logic j, input logic e,
                        input logic ey, input logic eb);
        exp_t ex;
        J  = j;
        en = e;
        exp_q.push_back('{y: ey, busy: eb});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            ex = exp_q.pop_front();
            check({name, ".Y"}, int'(Y), int'(ex.y));
            check({name, ".busy"}, int'(busy), int'(ex.busy));
        end
    endtask

    task automatic do_reset();
        J  = 1'b0;
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset.Y", int'(Y), 0);
        check("reset.busy", int'(busy), 0);
`ifdef GAP_SEQDET_MATCH_CNT_EN
        check("reset.match_cnt", int'(match_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"gap3_match",    3'd3, 1'b0, 10, 16'b1000100000, 16'b0000010000, 16'b0011101110};
        vecs[1] = '{"gap3_too_long", 3'd3, 1'b0, 7,  16'b1000010,    16'b0000000,    16'b0011100};
        vecs[2] = '{"gap3_too_short",3'd3, 1'b0, 9,  16'b100100000,  16'b000000000,  16'b001101110};
        vecs[3] = '{"gap2_ovl",      3'd2, 1'b0, 10, 16'b1001001000, 16'b0000100100, 16'b0011011011};
        vecs[4] = '{"gap2_novl",     3'd2, 1'b1, 10, 16'b1001001000, 16'b0000100000, 16'b0011000011};
        vecs[5] = '{"gap0_disabled", 3'd0, 1'b0, 8,  16'b10010110,   16'b00000000,   16'b00000000};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            gap  = vecs[v].gap;
            mode = vecs[v].mode;
            for (int i = 0; i < vecs[v].len; i++) begin
                step($sformatf("%s[%0d]", vecs[v].name, i),
                     vecs[v].j[vecs[v].len-1-i], 1'b1,
                     vecs[v].y[vecs[v].len-1-i], vecs[v].b[vecs[v].len-1-i]);
            end
        end

        // gap raised mid-count: the latched value of 2 still governs this frame.
        do_reset();
        gap  = 3'd2;
        mode = 1'b0;
        step("gapchg[0]", 1'b1, 1'b1, 1'b0, 1'b0);
        step("gapchg[1]", 1'b0, 1'b1, 1'b0, 1'b0);
        step("gapchg[2]", 1'b0, 1'b1, 1'b0, 1'b1);
        gap = 3'd5;
        step("gapchg[3]", 1'b1, 1'b1, 1'b0, 1'b1);
        step("gapchg[4]", 1'b0, 1'b1, 1'b1, 1'b0);
        step("gapchg[5]", 1'b0, 1'b1, 1'b0, 1'b1);

        // en alternating 1,0: each bit is held for two cycles so the enabled sample sees it.
        do_reset();
        gap  = 3'd2;
        mode = 1'b0;
        step("en[0]",  1'b1, 1'b1, 1'b0, 1'b0);
        step("en[1]",  1'b1, 1'b0, 1'b0, 1'b0);
        step("en[2]",  1'b0, 1'b1, 1'b0, 1'b0);
        step("en[3]",  1'b0, 1'b0, 1'b0, 1'b0);
        step("en[4]",  1'b0, 1'b1, 1'b0, 1'b1);
        step("en[5]",  1'b0, 1'b0, 1'b0, 1'b1);
        step("en[6]",  1'b1, 1'b1, 1'b0, 1'b1);
        step("en[7]",  1'b1, 1'b0, 1'b0, 1'b1);
        step("en[8]",  1'b0, 1'b1, 1'b1, 1'b0);
        step("en[9]",  1'b0, 1'b0, 1'b1, 1'b0);
        step("en[10]", 1'b0, 1'b1, 1'b0, 1'b1);
        step("en[11]", 1'b0, 1'b0, 1'b0, 1'b1);
        step("en[12]", 1'b0, 1'b1, 1'b0, 1'b1);
        step("en[13]", 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a frame; the tail of that frame must not match.
        do_reset();
        gap  = 3'd2;
        mode = 1'b0;
        step("rstmid[0]", 1'b1, 1'b1, 1'b0, 1'b0);
        step("rstmid[1]", 1'b0, 1'b1, 1'b0, 1'b0);
        step("rstmid[2]", 1'b0, 1'b1, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid.Y", int'(Y), 0);
        check("rstmid.busy", int'(busy), 0);
        #1;
        rst = 1'b0;
        step("rstmid[3]", 1'b0, 1'b1, 1'b0, 1'b0);
        step("rstmid[4]", 1'b1, 1'b1, 1'b0, 1'b0);
        step("rstmid[5]", 1'b0, 1'b1, 1'b0, 1'b0);
        step("rstmid[6]", 1'b0, 1'b1, 1'b0, 1'b1);
        step("rstmid[7]", 1'b0, 1'b1, 1'b0, 1'b1);
        step("rstmid[8]", 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef GAP_SEQDET_MATCH_CNT_EN
        do_reset();
        gap  = 3'd1;
        mode = 1'b0;
        step("cnt_pre[0]", 1'b1, 1'b1, 1'b0, 1'b0);
        step("cnt_pre[1]", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int m = 0; m < 300; m++) begin
            step($sformatf("cnt[%0d].a", m), 1'b1, 1'b1, 1'b0, 1'b1);
            step($sformatf("cnt[%0d].b", m), 1'b0, 1'b1, 1'b1, 1'b0);
            if (m == 0) check("match_cnt.first", int'(match_cnt), 1);
            if (m == 99) check("match_cnt.100", int'(match_cnt), 100);
        end
        check("match_cnt.saturated", int'(match_cnt), 255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
